// File: rtl/mod_updown_counter.sv
// mod_updown_counter: synchronous up/down modulo counter with clear, load,
// enable, terminal count and wrap indication. Successor to the 4-bit ripple
// counter; every flop is on clk so `count` is glitch-free.
//
// Optional feature macro: MOD_UPDOWN_COUNTER_PRESCALE_EN
//   When defined, adds parameter PRESCALE and an enable prescaler so the
//   counter steps once per PRESCALE enabled edges.
//
// Ports:
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   en           count enable
//   up_dn        direction, 1 = up, 0 = down
//   clr          synchronous clear to 0 (highest priority)
//   load         synchronous parallel load (clamped to MODULUS-1)
//   load_val     value taken on load
//   count        registered count value
//   tc           terminal count, combinational from registered state
//   wrap         one-cycle registered pulse following a wrapping edge
//   wrap_sticky  set on any wrap, cleared by clr or reset
`timescale 1ns/1ps
module mod_updown_counter #(
   parameter int unsigned     WIDTH     = 4,
   parameter longint unsigned MODULUS   = 16,
   parameter int unsigned     RESET_VAL = 0
`ifdef MOD_UPDOWN_COUNTER_PRESCALE_EN
   ,
   parameter int unsigned     PRESCALE  = 4
`endif
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             up_dn,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             wrap_sticky
);

   // One extra bit so MODULUS = 2^WIDTH is representable in comparisons
   localparam int unsigned    CW      = WIDTH + 1;
   localparam logic [CW-1:0]  MOD_EXT = CW'(MODULUS);
   localparam logic [CW-1:0]  MAX_EXT = CW'(MODULUS - 64'd1);
   localparam logic [WIDTH-1:0] MAX_VAL = MAX_EXT[WIDTH-1:0];
   localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             sticky_q, sticky_d;
   logic [CW-1:0]    count_ext_c;
   logic [CW-1:0]    load_ext_c;
   logic             at_max_c;
   logic             at_zero_c;
   logic             wrap_hit_c;
   logic             tick_c;

`ifdef MOD_UPDOWN_COUNTER_PRESCALE_EN
   localparam int unsigned   PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_q, pre_d;

   // Counter may only step on the last prescaler phase
   assign tick_c = (pre_q == PRE_LAST);
`else
   assign tick_c = 1'b1;
`endif

   // Boundary detection in the widened domain, never via natural overflow
   assign count_ext_c = {1'b0, count_q};
   assign load_ext_c  = {1'b0, load_val};
   assign at_max_c    = (count_ext_c == MAX_EXT);
   assign at_zero_c   = (count_q == '0);
   assign wrap_hit_c  = up_dn ? at_max_c : at_zero_c;

   assign tc          = wrap_hit_c & tick_c;
   assign count       = count_q;
   assign wrap        = wrap_q;
   assign wrap_sticky = sticky_q;

   // Next-state: clr > load > en > hold
   always_comb begin
      count_d  = count_q;
      wrap_d   = 1'b0;
      sticky_d = sticky_q;
`ifdef MOD_UPDOWN_COUNTER_PRESCALE_EN
      pre_d    = pre_q;
`endif
      if (clr) begin
         count_d  = '0;
         sticky_d = 1'b0;
`ifdef MOD_UPDOWN_COUNTER_PRESCALE_EN
         pre_d    = '0;
`endif
      end else if (load) begin
         count_d = (load_ext_c < MOD_EXT) ? load_val : MAX_VAL;
`ifdef MOD_UPDOWN_COUNTER_PRESCALE_EN
         pre_d   = '0;
`endif
      end else if (en) begin
`ifdef MOD_UPDOWN_COUNTER_PRESCALE_EN
         pre_d = tick_c ? '0 : pre_q + PW'(1);
`endif
         if (tick_c) begin
            if (wrap_hit_c) begin
               count_d  = up_dn ? '0 : MAX_VAL;
               wrap_d   = 1'b1;
               sticky_d = 1'b1;
            end else begin
               count_d = up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q  <= RST_VAL;
         wrap_q   <= 1'b0;
         sticky_q <= 1'b0;
`ifdef MOD_UPDOWN_COUNTER_PRESCALE_EN
         pre_q    <= '0;
`endif
      end else begin
         count_q  <= count_d;
         wrap_q   <= wrap_d;
         sticky_q <= sticky_d;
`ifdef MOD_UPDOWN_COUNTER_PRESCALE_EN
         pre_q    <= pre_d;
`endif
      end
   end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed testbench for mod_updown_counter: a default-parameter instance (a)
// and a MODULUS=10 / RESET_VAL=5 instance (b). Inputs change and outputs are
// sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_mod_updown_counter;

   logic       clk = 1'b0;
   int         errors = 0;
   int         checks = 0;

   logic       rstn_a, en_a, up_a, clr_a, load_a;
   logic [3:0] lv_a, count_a;
   logic       tc_a, wrap_a, ws_a;

   logic       rstn_b, en_b, up_b, clr_b, load_b;
   logic [3:0] lv_b, count_b;
   logic       tc_b, wrap_b, ws_b;

   always #5 clk = ~clk;

   mod_updown_counter u_dut_a (
      .clk(clk), .rstn(rstn_a), .en(en_a), .up_dn(up_a), .clr(clr_a),
      .load(load_a), .load_val(lv_a), .count(count_a), .tc(tc_a),
      .wrap(wrap_a), .wrap_sticky(ws_a)
   );

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(5)) u_dut_b (
      .clk(clk), .rstn(rstn_b), .en(en_b), .up_dn(up_b), .clr(clr_b),
      .load(load_b), .load_val(lv_b), .count(count_b), .tc(tc_b),
      .wrap(wrap_b), .wrap_sticky(ws_b)
   );

   task automatic test_reset();
      rstn_a = 1'b0; en_a = 1'b0; up_a = 1'b1; clr_a = 1'b0; load_a = 1'b0; lv_a = 4'd0;
      rstn_b = 1'b0; en_b = 1'b0; up_b = 1'b1; clr_b = 1'b0; load_b = 1'b0; lv_b = 4'd0;
      repeat (3) @(negedge clk);
      checks++; if (count_a !== 4'd0) begin errors++; $display("FAIL reset_count_a got=%0d exp=0", count_a); end
      checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL reset_wrap_a got=%b exp=0", wrap_a); end
      checks++; if (ws_a !== 1'b0) begin errors++; $display("FAIL reset_sticky_a got=%b exp=0", ws_a); end
      checks++; if (tc_a !== 1'b0) begin errors++; $display("FAIL reset_tc_a got=%b exp=0", tc_a); end
      checks++; if (count_b !== 4'd5) begin errors++; $display("FAIL reset_count_b got=%0d exp=5", count_b); end
      checks++; if (tc_b !== 1'b0) begin errors++; $display("FAIL reset_tc_b got=%b exp=0", tc_b); end
   endtask

   task automatic test_up_count();
      rstn_a = 1'b1; en_a = 1'b1; up_a = 1'b1;
      for (int i = 0; i < 20; i++) begin
         checks++; if (count_a !== 4'(i % 16)) begin errors++; $display("FAIL up_count[%0d] got=%0d exp=%0d", i, count_a, i % 16); end
         checks++; if (wrap_a !== (i == 16)) begin errors++; $display("FAIL up_wrap[%0d] got=%b exp=%b", i, wrap_a, (i == 16)); end
         checks++; if (tc_a !== ((i % 16) == 15)) begin errors++; $display("FAIL up_tc[%0d] got=%b exp=%b", i, tc_a, ((i % 16) == 15)); end
         checks++; if (ws_a !== (i >= 16)) begin errors++; $display("FAIL up_sticky[%0d] got=%b exp=%b", i, ws_a, (i >= 16)); end
         @(negedge clk);
      end
      en_a = 1'b0;
   endtask

   task automatic test_en_toggle();
      load_a = 1'b1; lv_a = 4'd15;
      @(negedge clk);
      load_a = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++; if (count_a !== 4'd15) begin errors++; $display("FAIL hold_count[%0d] got=%0d exp=15", i, count_a); end
         checks++; if (tc_a !== 1'b1) begin errors++; $display("FAIL hold_tc[%0d] got=%b exp=1", i, tc_a); end
         checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL hold_wrap[%0d] got=%b exp=0", i, wrap_a); end
         @(negedge clk);
      end
      en_a = 1'b1;
      @(negedge clk);
      en_a = 1'b0;
      checks++; if (count_a !== 4'd0) begin errors++; $display("FAIL toggle_wrap_count got=%0d exp=0", count_a); end
      checks++; if (wrap_a !== 1'b1) begin errors++; $display("FAIL toggle_wrap_pulse got=%b exp=1", wrap_a); end
      @(negedge clk);
      checks++; if (count_a !== 4'd0) begin errors++; $display("FAIL toggle_after_count got=%0d exp=0", count_a); end
      checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL toggle_after_wrap got=%b exp=0", wrap_a); end
   endtask

   task automatic test_load_over_en();
      en_a = 1'b1; up_a = 1'b1; load_a = 1'b1; lv_a = 4'd3;
      @(negedge clk);
      load_a = 1'b0; up_a = 1'b0;
      checks++; if (count_a !== 4'd3) begin errors++; $display("FAIL load_wins_count got=%0d exp=3", count_a); end
      checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL load_wins_wrap got=%b exp=0", wrap_a); end
      @(negedge clk);
      up_a = 1'b1;
      checks++; if (count_a !== 4'd2) begin errors++; $display("FAIL dir_down_count got=%0d exp=2", count_a); end
      @(negedge clk);
      en_a = 1'b0;
      checks++; if (count_a !== 4'd3) begin errors++; $display("FAIL dir_up_count got=%0d exp=3", count_a); end
   endtask

   task automatic test_count_down();
      logic [3:0] exp_cnt [5] = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
      logic       exp_wr  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic       exp_tc  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      rstn_b = 1'b1; up_b = 1'b0; load_b = 1'b1; lv_b = 4'd2;
      @(negedge clk);
      load_b = 1'b0; en_b = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (count_b !== exp_cnt[i]) begin errors++; $display("FAIL down_count[%0d] got=%0d exp=%0d", i, count_b, exp_cnt[i]); end
         checks++; if (wrap_b !== exp_wr[i]) begin errors++; $display("FAIL down_wrap[%0d] got=%b exp=%b", i, wrap_b, exp_wr[i]); end
         checks++; if (tc_b !== exp_tc[i]) begin errors++; $display("FAIL down_tc[%0d] got=%b exp=%b", i, tc_b, exp_tc[i]); end
         @(negedge clk);
      end
      en_b = 1'b0;
      checks++; if (ws_b !== 1'b1) begin errors++; $display("FAIL down_sticky got=%b exp=1", ws_b); end
   endtask

   task automatic test_load_clamp();
      load_b = 1'b1; lv_b = 4'd13;
      @(negedge clk);
      load_b = 1'b0;
      checks++; if (count_b !== 4'd9) begin errors++; $display("FAIL clamp_count got=%0d exp=9", count_b); end
      checks++; if (ws_b !== 1'b1) begin errors++; $display("FAIL clamp_sticky_kept got=%b exp=1", ws_b); end
      clr_b = 1'b1; load_b = 1'b1; lv_b = 4'd4;
      @(negedge clk);
      clr_b = 1'b0; load_b = 1'b0;
      checks++; if (count_b !== 4'd0) begin errors++; $display("FAIL clr_over_load_count got=%0d exp=0", count_b); end
      checks++; if (ws_b !== 1'b0) begin errors++; $display("FAIL clr_sticky got=%b exp=0", ws_b); end
   endtask

   task automatic test_async_reset();
      load_b = 1'b1; lv_b = 4'd7; up_b = 1'b1;
      @(negedge clk);
      load_b = 1'b0; en_b = 1'b1;
      checks++; if (count_b !== 4'd7) begin errors++; $display("FAIL pre_reset_count got=%0d exp=7", count_b); end
      #2;
      rstn_b = 1'b0;
      #1;
      checks++; if (count_b !== 4'd5) begin errors++; $display("FAIL async_reset_count got=%0d exp=5", count_b); end
      checks++; if (wrap_b !== 1'b0) begin errors++; $display("FAIL async_reset_wrap got=%b exp=0", wrap_b); end
      @(negedge clk);
      checks++; if (count_b !== 4'd5) begin errors++; $display("FAIL held_reset_count got=%0d exp=5", count_b); end
      rstn_b = 1'b1;
      @(negedge clk);
      en_b = 1'b0;
      checks++; if (count_b !== 4'd6) begin errors++; $display("FAIL post_reset_step got=%0d exp=6", count_b); end
   endtask

`ifdef MOD_UPDOWN_COUNTER_PRESCALE_EN
   task automatic test_prescale();
      rstn_a = 1'b1; clr_a = 1'b1; en_a = 1'b0; up_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0; en_a = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++; if (count_a !== 4'(i / 4)) begin errors++; $display("FAIL pre_count[%0d] got=%0d exp=%0d", i, count_a, i / 4); end
         @(negedge clk);
      end
      checks++; if (count_a !== 4'd4) begin errors++; $display("FAIL pre_final got=%0d exp=4", count_a); end
      repeat (2) @(negedge clk);
      load_a = 1'b1; lv_a = 4'd10;
      @(negedge clk);
      load_a = 1'b0;
      checks++; if (count_a !== 4'd10) begin errors++; $display("FAIL pre_load got=%0d exp=10", count_a); end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         checks++; if (count_a !== ((k < 4) ? 4'd10 : 4'd11)) begin errors++; $display("FAIL pre_restart[%0d] got=%0d exp=%0d", k, count_a, (k < 4) ? 10 : 11); end
      end
      en_a = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
`ifdef MOD_UPDOWN_COUNTER_PRESCALE_EN
      test_prescale();
`else
      test_up_count();
      test_en_toggle();
      test_load_over_en();
      test_count_down();
      test_load_clamp();
      test_async_reset();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
